// File: rtl/mvu_job_responder_if.sv
// CSR/start/irq bundle between a pito hart lane and its MVU job responder.
// Carries start_err only when MVU_JOB_START_ERR_EN is defined.
interface mvu_job_responder_if #(
  parameter int ADDR_W = 15
);
  logic              mvu_start;
  logic [31:0]       csr_mvuwbaseptr;
  logic [31:0]       csr_mvuwjump_0;
  logic [31:0]       csr_mvuwjump_1;
  logic [31:0]       csr_mvuwlength_1;
  logic [31:0]       csr_mvucommand;
  logic [ADDR_W-1:0] waddr;
  logic              waddr_valid;
  logic              waddr_ready;
  logic              mvu_irq;
  logic              irq_ack;
  logic              busy;
`ifdef MVU_JOB_START_ERR_EN
  logic              start_err;
`endif

  modport master (
    output mvu_start, csr_mvuwbaseptr, csr_mvuwjump_0, csr_mvuwjump_1,
           csr_mvuwlength_1, csr_mvucommand, waddr_ready, irq_ack,
`ifdef MVU_JOB_START_ERR_EN
    input  start_err,
`endif
    input  waddr, waddr_valid, mvu_irq, busy
  );

  modport slave (
    input  mvu_start, csr_mvuwbaseptr, csr_mvuwjump_0, csr_mvuwjump_1,
           csr_mvuwlength_1, csr_mvucommand, waddr_ready, irq_ack,
`ifdef MVU_JOB_START_ERR_EN
    output start_err,
`endif
    output waddr, waddr_valid, mvu_irq, busy
  );
endinterface

// File: rtl/mvu_job_responder.sv
// MVU job responder: snapshots weight CSRs on start, walks a two-level address loop, holds irq until ack.
// Optional sticky start_err flag for ignored starts under MVU_JOB_START_ERR_EN.
module mvu_job_responder #(
  parameter int ADDR_W = 15,
  parameter int CNT_W  = 16
) (
  input logic              clk,
  input logic              rst,
  mvu_job_responder_if.slave bus
);

  // IDLE | waiting for start    RUN | issuing addresses    DONE | irq held until ack
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] jump0_q, jump0_d;
  logic [ADDR_W-1:0] jump1_q, jump1_d;
  logic [CNT_W-1:0]  icnt_q, icnt_d;
  logic [CNT_W-1:0]  ocnt_q, ocnt_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic              valid_q, valid_d;
  logic              irq_q, irq_d;
  logic              busy_q, busy_d;
  logic              load;

  logic unused_csr_bits;
  assign unused_csr_bits = ^{bus.csr_mvuwbaseptr[31:ADDR_W], bus.csr_mvuwjump_0[31:ADDR_W],
                             bus.csr_mvuwjump_1[31:ADDR_W], bus.csr_mvuwlength_1[31:CNT_W],
                             bus.csr_mvucommand[31:CNT_W]};

`ifdef MVU_JOB_START_ERR_EN
  logic err_q, err_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      jump0_q <= '0;
      jump1_q <= '0;
      icnt_q  <= '0;
      ocnt_q  <= '0;
      len_q   <= '0;
      valid_q <= 1'b0;
      irq_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      jump0_q <= jump0_d;
      jump1_q <= jump1_d;
      icnt_q  <= icnt_d;
      ocnt_q  <= ocnt_d;
      len_q   <= len_d;
      valid_q <= valid_d;
      irq_q   <= irq_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    jump0_d = jump0_q;
    jump1_d = jump1_q;
    icnt_d  = icnt_q;
    ocnt_d  = ocnt_q;
    len_d   = len_q;
    load    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.mvu_start) load = 1'b1;
      end
      RUN: begin
        if (valid_q && bus.waddr_ready) begin
          if (icnt_q == '0 && ocnt_q == '0) begin
            state_d = DONE;
          end else if (icnt_q == '0) begin
            icnt_d = len_q;
            ocnt_d = ocnt_q - 1'b1;
            addr_d = addr_q + jump1_q;
          end else begin
            icnt_d = icnt_q - 1'b1;
            addr_d = addr_q + jump0_q;
          end
        end
      end
      DONE: begin
        if (bus.irq_ack) begin
          if (bus.mvu_start) load = 1'b1;
          else               state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A start accepted in IDLE or together with ack in DONE takes a fresh snapshot.
    if (load) begin
      state_d = RUN;
      addr_d  = bus.csr_mvuwbaseptr[ADDR_W-1:0];
      jump0_d = bus.csr_mvuwjump_0[ADDR_W-1:0];
      jump1_d = bus.csr_mvuwjump_1[ADDR_W-1:0];
      len_d   = bus.csr_mvuwlength_1[CNT_W-1:0];
      icnt_d  = bus.csr_mvuwlength_1[CNT_W-1:0];
      ocnt_d  = bus.csr_mvucommand[CNT_W-1:0];
    end

    valid_d = (state_d == RUN);
    irq_d   = (state_d == DONE);
    busy_d  = (state_d != IDLE);
  end

  assign bus.waddr       = addr_q;
  assign bus.waddr_valid = valid_q;
  assign bus.mvu_irq     = irq_q;
  assign bus.busy        = busy_q;

`ifdef MVU_JOB_START_ERR_EN
  always_comb begin
    err_d = err_q;
    if (state_q == DONE && bus.irq_ack)
      err_d = 1'b0;
    else if (bus.mvu_start && (state_q == RUN || state_q == DONE))
      err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign bus.start_err = err_q;
`endif

endmodule
